bp_be_fp_result_pipe: RTL and testbench
=======================================

Name: bp_be_fp_result_pipe

Overview:
- Downstream neighbour of the hardfloat FPU. It consumes the FPU's combinational result and exception flags (one op per cycle).
- Retimes the result through a fixed-depth pipeline and NaN-boxes single-precision FP-destination results.
- Accumulates the sticky fflags CSR from retiring ops. Supports pipeline stall, flush, and CSR read/write of fflags.

Parameters:
- dword_width_p, 64, datapath width.
- latency_p, 3, pipeline depth in cycles (legal range 1..8).
- reg_addr_width_p, 5, destination register index width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- v_i  in  1  FPU op valid this cycle; ignored while stall_i=1.
- result_i  in  dword_width_p  FPU result o. For SP FP-dest ops, the SP encoding is in bits [31:0].
- eflags_i  in  5  bsg_fp_eflags_s {nv,dz,of,uf,nx} from FPU.
- opr_i  in  1  bsg_fp_pr_e output precision (e_pr_double / e_pr_single).
- fp_dest_i  in  1  1 = writes FP regfile, 0 = writes integer regfile.
- rd_addr_i  in  reg_addr_width_p  destination register.
- stall_i  in  1  freeze all stages.
- flush_i  in  1  kill all in-flight ops.
- fflags_w_v_i  in  1  CSR write of fflags.
- fflags_w_data_i  in  5  CSR write data.
- v_o  out  1  retiring op valid.
- data_o  out  dword_width_p  retiring result.
- fp_dest_o  out  1  retiring op destination file.
- rd_addr_o  out  reg_addr_width_p  retiring destination register.
- fflags_o  out  5  current sticky fflags.

Behaviour:
- Reset:
  - All stage valid bits 0; v_o=0.
  - data_o, rd_addr_o, fp_dest_o = 0.
  - fflags_o = 5'b0.
- Latency:
  - An op accepted at cycle t (v_i=1, stall_i=0, flush_i=0) appears on v_o at cycle t+latency_p, provided no stalls occur.
  - Each stalled cycle adds one cycle of latency.
- Stage 0 capture:
  - data is {32'hFFFF_FFFF, result_i[31:0]} when opr_i=e_pr_single and fp_dest_i=1.
  - Otherwise data is result_i unchanged.
  - eflags, rd_addr and fp_dest are captured alongside.
- Stall: with stall_i=1 and flush_i=0, every stage holds (valid and payload). v_i is ignored and v_o holds its value. The downstream consumer must not retire while stalled.
- Flush:
  - flush_i=1 clears every stage valid bit next edge, including any op presented on v_i that cycle.
  - Flush overrides stall.
  - Flushed ops never update fflags.
  - Payload registers need not clear.
- Retire: an op retires in a cycle where the last stage is valid, stall_i=0 and flush_i=0. Its eflags are ORed into fflags at the following edge.
- fflags update priority, per edge:
  - reset;
  - else fflags_w_v_i: fflags <= fflags_w_data_i. A retire in the same cycle is dropped, because the CSR write is younger in program order.
  - else retire: fflags <= fflags | retiring eflags;
  - else hold.
- A CSR write is accepted regardless of stall_i or flush_i.
- fflags_o is registered: it reflects updates one cycle after the retire or write.
- latency_p=1 degenerates to a single register stage. All rules above still hold.
- Reset mid-operation discards all in-flight ops with no fflags update.
- Simultaneous reset and flush: reset dominates, with identical outcome.

Decomposition:
- Shared bp_be_hardfloat_pkg carries:
  - bsg_fp_eflags_s and bsg_fp_pr_e (already present);
  - a new bp_be_fp_pipe_stage_s {v, fp_dest, rd_addr, eflags, data};
  - a localparam for the NaN-box constant 32'hFFFF_FFFF.
- One natural sub-module, bp_be_fp_pipe_stage: one stage register with stall/flush. It is instantiated latency_p times in a generate loop.
- The fflags accumulator stays in the top module.

Test Plan:
- Reset, then single DP op: v_i=1, result_i=64'h4000_0000_0000_0000, opr=double, fp_dest=1, eflags=5'b00001 at t0 -> v_o=1 at t0+3, data_o=64'h4000_0000_0000_0000; fflags_o=5'b00001 at t0+4.
- SP boxing: result_i=64'h0000_0000_3F80_0000, opr=single, fp_dest=1 -> data_o=64'hFFFF_FFFF_3F80_0000. The same op with fp_dest=0 -> data_o=64'h0000_0000_3F80_0000.
- Back-to-back 4 ops with eflags nv, dz, of, nx, with a 2-cycle stall_i pulse mid-flight -> 4 retirements in order, the stall adds 2 cycles, fflags_o=5'b11101 after the last retire.
- Flush with 3 ops in flight plus one on v_i -> no v_o for the next 3 cycles, fflags unchanged. A new op issued the cycle after flush retires normally.
- Collision: retire with eflags=5'b10000 in the same cycle as fflags_w_v_i=1, data=5'b00010 -> fflags_o=5'b00010. A following retire with 5'b00001 -> 5'b00011.
- Reset asserted with 2 ops in flight and fflags=5'b11111 -> next cycle v_o=0, fflags_o=0, and no retire occurs in the following 3 cycles.

Source files
------------

// File: rtl/bp_be_hardfloat_pkg.sv
// -----------------------------------------------------------------------------
// bp_be_hardfloat_pkg
//
// Types shared between the hardfloat FPU and its downstream neighbours.
//
//   bsg_fp_eflags_s        : IEEE exception flags {nv, dz, of, uf, nx}
//   bsg_fp_pr_e            : output precision of an FP operation
//   bp_be_fp_pipe_stage_s  : one result-pipe stage in its default geometry
//                            (64-bit datapath, 5-bit register index)
//   nanbox_value_gp        : upper-word pattern for NaN-boxed SP values
// -----------------------------------------------------------------------------
package bp_be_hardfloat_pkg;

    // Exception flags in the same bit order as the fflags CSR.
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } bsg_fp_eflags_s;

    // Output precision of an FP operation.
    typedef enum logic {
        e_pr_double = 1'b0,
        e_pr_single = 1'b1
    } bsg_fp_pr_e;

    // Default geometry of the result pipe.
    localparam int unsigned fp_pipe_dword_width_gp    = 64;
    localparam int unsigned fp_pipe_reg_addr_width_gp = 5;
    localparam int unsigned fp_eflags_width_gp        = 5;

    // A single-precision value held in a 64-bit FP register carries all
    // ones in its upper word so it reads as a NaN when used as double.
    localparam logic [31:0] nanbox_value_gp = 32'hFFFF_FFFF;

    // One pipe stage: valid plus payload.
    typedef struct packed {
        logic                                 v;
        logic                                 fp_dest;
        logic [fp_pipe_reg_addr_width_gp-1:0] rd_addr;
        bsg_fp_eflags_s                       eflags;
        logic [fp_pipe_dword_width_gp-1:0]    data;
    } bp_be_fp_pipe_stage_s;

endpackage

// File: rtl/bp_be_fp_pipe_stage.sv
// -----------------------------------------------------------------------------
// bp_be_fp_pipe_stage
//
// One register stage of the FP result pipe: a valid bit plus an opaque
// payload vector.
//
// Ports
//   clk_i     in   clock
//   reset_i   in   synchronous active-high reset (clears valid and payload)
//   stall_i   in   hold valid and payload
//   flush_i   in   clear valid (payload left as is); overrides stall
//   v_i       in   valid from the previous stage
//   data_i    in   payload from the previous stage
//   v_o       out  registered valid
//   data_o    out  registered payload
// -----------------------------------------------------------------------------
module bp_be_fp_pipe_stage
    import bp_be_hardfloat_pkg::*;
#(
    parameter int unsigned width_p = 75
)
(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o
);

    logic               v_r;
    logic [width_p-1:0] data_r;

    // Valid bit: reset and flush kill, stall holds, otherwise advance.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_r <= 1'b0;
        end else if (flush_i) begin
            v_r <= 1'b0;
        end else if (stall_i) begin
            v_r <= v_r;
        end else begin
            v_r <= v_i;
        end
    end

    // Payload: a flushed stage keeps stale payload; only its valid drops.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_r <= '0;
        end else if (stall_i || flush_i) begin
            data_r <= data_r;
        end else begin
            data_r <= data_i;
        end
    end

    assign v_o    = v_r;
    assign data_o = data_r;

endmodule

// File: rtl/bp_be_fp_result_pipe.sv
// -----------------------------------------------------------------------------
// bp_be_fp_result_pipe
//
// Retimes the FPU result through latency_p register stages, NaN-boxes
// single-precision results headed for the FP register file and keeps the
// sticky fflags CSR up to date from retiring operations.
//
// Ports
//   clk_i            in   clock
//   reset_i          in   synchronous active-high reset
//   v_i              in   FPU op valid (ignored while stalled)
//   result_i         in   FPU result; SP results live in bits [31:0]
//   eflags_i         in   exception flags {nv,dz,of,uf,nx}
//   opr_i            in   output precision (bsg_fp_pr_e)
//   fp_dest_i        in   1 = FP regfile destination, 0 = integer regfile
//   rd_addr_i        in   destination register index
//   stall_i          in   freeze every stage
//   flush_i          in   kill every in-flight op (overrides stall)
//   fflags_w_v_i     in   CSR write of fflags
//   fflags_w_data_i  in   CSR write data
//   v_o              out  retiring op valid
//   data_o           out  retiring result
//   fp_dest_o        out  retiring op destination file
//   rd_addr_o        out  retiring destination register
//   fflags_o         out  current sticky fflags
// -----------------------------------------------------------------------------
module bp_be_fp_result_pipe
    import bp_be_hardfloat_pkg::*;
#(
    parameter int unsigned dword_width_p    = 64,
    parameter int unsigned latency_p        = 3,
    parameter int unsigned reg_addr_width_p = 5
)
(
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        v_i,
    input  logic [dword_width_p-1:0]    result_i,
    input  logic [4:0]                  eflags_i,
    input  logic                        opr_i,
    input  logic                        fp_dest_i,
    input  logic [reg_addr_width_p-1:0] rd_addr_i,
    input  logic                        stall_i,
    input  logic                        flush_i,
    input  logic                        fflags_w_v_i,
    input  logic [4:0]                  fflags_w_data_i,
    output logic                        v_o,
    output logic [dword_width_p-1:0]    data_o,
    output logic                        fp_dest_o,
    output logic [reg_addr_width_p-1:0] rd_addr_o,
    output logic [4:0]                  fflags_o
);

    // Payload layout, MSB first: {fp_dest, rd_addr, eflags, data}.
    localparam int unsigned eflags_lsb_lp     = dword_width_p;
    localparam int unsigned rd_addr_lsb_lp    = eflags_lsb_lp + fp_eflags_width_gp;
    localparam int unsigned fp_dest_bit_lp    = rd_addr_lsb_lp + reg_addr_width_p;
    localparam int unsigned payload_width_lp  = fp_dest_bit_lp + 1;

    logic [dword_width_p-1:0]    boxed_data_s;
    logic                        v_chain_s       [latency_p:0];
    logic [payload_width_lp-1:0] payload_chain_s [latency_p:0];
    logic                        retire_s;
    logic [4:0]                  retire_eflags_s;
    logic [4:0]                  fflags_r;

    // NaN-box single-precision results that land in the FP register file.
    always_comb begin
        boxed_data_s = result_i;
        if ((bsg_fp_pr_e'(opr_i) == e_pr_single) && fp_dest_i) begin
            boxed_data_s[63:32] = nanbox_value_gp;
        end else begin
            boxed_data_s = result_i;
        end
    end

    assign v_chain_s[0]       = v_i;
    assign payload_chain_s[0] = {fp_dest_i, rd_addr_i, eflags_i, boxed_data_s};

    for (genvar i = 0; i < latency_p; i++) begin : g_stage
        bp_be_fp_pipe_stage #(
            .width_p (payload_width_lp)
        ) stage (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .stall_i (stall_i),
            .flush_i (flush_i),
            .v_i     (v_chain_s[i]),
            .data_i  (payload_chain_s[i]),
            .v_o     (v_chain_s[i+1]),
            .data_o  (payload_chain_s[i+1])
        );
    end

    assign v_o       = v_chain_s[latency_p];
    assign data_o    = payload_chain_s[latency_p][dword_width_p-1:0];
    assign rd_addr_o = payload_chain_s[latency_p][rd_addr_lsb_lp +: reg_addr_width_p];
    assign fp_dest_o = payload_chain_s[latency_p][fp_dest_bit_lp];

    // The consumer only takes the op when the pipe is moving.
    assign retire_s        = v_o & ~stall_i & ~flush_i;
    assign retire_eflags_s = payload_chain_s[latency_p][eflags_lsb_lp +: fp_eflags_width_gp];

    // Sticky fflags: a CSR write is younger than a same-cycle retire, so it wins.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fflags_r <= 5'b00000;
        end else if (fflags_w_v_i) begin
            fflags_r <= fflags_w_data_i;
        end else if (retire_s) begin
            fflags_r <= fflags_r | retire_eflags_s;
        end else begin
            fflags_r <= fflags_r;
        end
    end

    assign fflags_o = fflags_r;

endmodule

// File: tb/tb_bp_be_fp_result_pipe.sv
module tb_bp_be_fp_result_pipe;
    import bp_be_hardfloat_pkg::*;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        v_i = 1'b0;
    logic [63:0] result_i = 64'h0;
    logic [4:0]  eflags_i = 5'b0;
    logic        opr_i = 1'b0;
    logic        fp_dest_i = 1'b0;
    logic [4:0]  rd_addr_i = 5'd0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        fflags_w_v_i = 1'b0;
    logic [4:0]  fflags_w_data_i = 5'b0;
    logic        v_o;
    logic [63:0] data_o;
    logic        fp_dest_o;
    logic [4:0]  rd_addr_o;
    logic [4:0]  fflags_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bp_be_fp_result_pipe #(
        .dword_width_p    (64),
        .latency_p        (LAT),
        .reg_addr_width_p (5)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .v_i             (v_i),
        .result_i        (result_i),
        .eflags_i        (eflags_i),
        .opr_i           (opr_i),
        .fp_dest_i       (fp_dest_i),
        .rd_addr_i       (rd_addr_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .fflags_w_v_i    (fflags_w_v_i),
        .fflags_w_data_i (fflags_w_data_i),
        .v_o             (v_o),
        .data_o          (data_o),
        .fp_dest_o       (fp_dest_o),
        .rd_addr_o       (rd_addr_o),
        .fflags_o        (fflags_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each accepted op carries the number of moving edges it still needs
    // before it shows on the output; stalls simply do not count down.
    typedef struct {
        logic [63:0] data;
        logic [4:0]  ef;
        logic [4:0]  rd;
        logic        fp;
        int          rem;
    } op_t;

    op_t   q[$];
    logic [4:0] m_ff = 5'b0;
    bit    m_live = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (reset_i) begin
                q.delete();
                m_ff = 5'b0;
                m_live = 1;
            end else begin
                bit retire;
                retire = (q.size() > 0) && (q[0].rem == 0) && !stall_i && !flush_i;
                if (fflags_w_v_i) m_ff = fflags_w_data_i;
                else if (retire)  m_ff = m_ff | q[0].ef;
                if (flush_i) begin
                    q.delete();
                end else if (!stall_i) begin
                    if (retire) void'(q.pop_front());
                    foreach (q[k]) q[k].rem = q[k].rem - 1;
                    if (v_i) begin
                        op_t n;
                        n.data = (opr_i && fp_dest_i) ? {32'hFFFF_FFFF, result_i[31:0]} : result_i;
                        n.ef   = eflags_i;
                        n.rd   = rd_addr_i;
                        n.fp   = fp_dest_i;
                        n.rem  = LAT - 1;
                        q.push_back(n);
                    end
                end
            end
        end
    end

    // Compare process: outputs against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                bit ev;
                ev = (q.size() > 0) && (q[0].rem == 0);
                chk("model_v", {63'b0, v_o}, {63'b0, ev});
                chk("model_fflags", {59'b0, fflags_o}, {59'b0, m_ff});
                if (ev) begin
                    chk("model_data", data_o, q[0].data);
                    chk("model_rd", {59'b0, rd_addr_o}, {59'b0, q[0].rd});
                    chk("model_fp", {63'b0, fp_dest_o}, {63'b0, q[0].fp});
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [63:0] res, input logic [4:0] ef,
                         input logic pr, input logic fpd, input logic [4:0] rd);
        v_i = 1'b1; result_i = res; eflags_i = ef; opr_i = pr; fp_dest_i = fpd; rd_addr_i = rd;
        step();
        v_i = 1'b0;
    endtask

    task automatic csr_write(input logic [4:0] d);
        fflags_w_v_i = 1'b1; fflags_w_data_i = d;
        step();
        fflags_w_v_i = 1'b0;
    endtask

    initial begin
        // Reset
        step(); step();
        reset_i = 1'b0;
        chk("reset_v", {63'b0, v_o}, 64'd0);
        chk("reset_data", data_o, 64'd0);
        chk("reset_rd", {59'b0, rd_addr_o}, 64'd0);
        chk("reset_fp", {63'b0, fp_dest_o}, 64'd0);
        chk("reset_fflags", {59'b0, fflags_o}, 64'd0);

        // Single DP op
        issue(64'h4000_0000_0000_0000, 5'b00001, e_pr_double, 1'b1, 5'd7);
        step();
        chk("dp_early_v", {63'b0, v_o}, 64'd0);
        step();
        chk("dp_v", {63'b0, v_o}, 64'd1);
        chk("dp_data", data_o, 64'h4000_0000_0000_0000);
        chk("dp_rd", {59'b0, rd_addr_o}, 64'd7);
        chk("dp_fflags_before", {59'b0, fflags_o}, 64'd0);
        step();
        chk("dp_fflags", {59'b0, fflags_o}, 64'h01);
        chk("dp_v_gone", {63'b0, v_o}, 64'd0);

        // SP boxing
        issue(64'h0000_0000_3F80_0000, 5'b0, e_pr_single, 1'b1, 5'd1);
        issue(64'h0000_0000_3F80_0000, 5'b0, e_pr_single, 1'b0, 5'd2);
        step();
        chk("sp_box", data_o, 64'hFFFF_FFFF_3F80_0000);
        step();
        chk("sp_int", data_o, 64'h0000_0000_3F80_0000);
        chk("sp_int_fp", {63'b0, fp_dest_o}, 64'd0);
        step();

        // Back-to-back with a 2-cycle stall
        csr_write(5'b00000);
        chk("clr_fflags", {59'b0, fflags_o}, 64'd0);
        issue(64'h11, 5'b10000, e_pr_double, 1'b1, 5'd1);
        issue(64'h22, 5'b01000, e_pr_double, 1'b1, 5'd2);
        issue(64'h33, 5'b00100, e_pr_double, 1'b1, 5'd3);
        issue(64'h44, 5'b00001, e_pr_double, 1'b1, 5'd4);
        stall_i = 1'b1;
        step();
        step();
        chk("stall_hold_v", {63'b0, v_o}, 64'd1);
        chk("stall_hold_rd", {59'b0, rd_addr_o}, 64'd2);
        chk("stall_fflags", {59'b0, fflags_o}, 64'h10);
        stall_i = 1'b0;
        step();
        chk("after_stall_rd", {59'b0, rd_addr_o}, 64'd3);
        step();
        chk("last_rd", {59'b0, rd_addr_o}, 64'd4);
        step();
        chk("b2b_fflags", {59'b0, fflags_o}, 64'h1D);
        chk("b2b_v_gone", {63'b0, v_o}, 64'd0);

        // Flush with 3 in flight plus one on v_i
        issue(64'h55, 5'b00010, e_pr_double, 1'b1, 5'd5);
        issue(64'h66, 5'b00010, e_pr_double, 1'b1, 5'd6);
        issue(64'h77, 5'b00010, e_pr_double, 1'b1, 5'd7);
        flush_i = 1'b1;
        issue(64'h88, 5'b00010, e_pr_double, 1'b1, 5'd8);
        flush_i = 1'b0;
        chk("flush_v0", {63'b0, v_o}, 64'd0);
        issue(64'h99, 5'b00010, e_pr_double, 1'b1, 5'd9);
        chk("flush_v1", {63'b0, v_o}, 64'd0);
        chk("flush_fflags", {59'b0, fflags_o}, 64'h1D);
        step();
        chk("flush_v2", {63'b0, v_o}, 64'd0);
        step();
        chk("post_flush_v", {63'b0, v_o}, 64'd1);
        chk("post_flush_rd", {59'b0, rd_addr_o}, 64'd9);
        step();
        chk("post_flush_fflags", {59'b0, fflags_o}, 64'h1F);

        // CSR write colliding with a retire
        csr_write(5'b00000);
        issue(64'hA0, 5'b10000, e_pr_double, 1'b1, 5'd10);
        issue(64'hB0, 5'b00001, e_pr_double, 1'b1, 5'd11);
        step();
        csr_write(5'b00010);
        chk("collide_fflags", {59'b0, fflags_o}, 64'h02);
        step();
        chk("after_collide_fflags", {59'b0, fflags_o}, 64'h03);

        // Reset (with flush) mid-operation
        csr_write(5'b11111);
        issue(64'hC0, 5'b10000, e_pr_double, 1'b1, 5'd12);
        issue(64'hD0, 5'b10000, e_pr_double, 1'b1, 5'd13);
        reset_i = 1'b1; flush_i = 1'b1;
        step();
        reset_i = 1'b0; flush_i = 1'b0;
        chk("midreset_v", {63'b0, v_o}, 64'd0);
        chk("midreset_fflags", {59'b0, fflags_o}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("midreset_quiet_v", {63'b0, v_o}, 64'd0);
            chk("midreset_quiet_fflags", {59'b0, fflags_o}, 64'd0);
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
